// File: rtl/seg_pkg.sv
// Shared constants for the segment-bus encoder: segment patterns {a..g},
// digit codes and the stability-filter state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [2:0] CODE_0 = 3'b000;
    localparam logic [2:0] CODE_1 = 3'b001;
    localparam logic [2:0] CODE_2 = 3'b010;
    localparam logic [2:0] CODE_3 = 3'b011;
    localparam logic [2:0] CODE_E = 3'b100;

    typedef enum logic {
        TRACK    = 1'b0,
        REPORTED = 1'b1
    } filt_state_e;

endpackage

// File: rtl/seg_stability_filter.sv
// Glitch filter: sample register, saturating run counter and TRACK/REPORTED FSM.
// 'stable' is asserted for the edge on which a pattern is to be reported.
module seg_stability_filter
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] pins,
    output logic       stable,
    output logic [6:0] pattern
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       sample_q, sample_d;
    logic [CNT_W-1:0] run_q, run_d;
    filt_state_e      state_q, state_d;
    logic             changed;

    always_comb begin
        changed  = (pins != sample_q);
        sample_d = pins;
        if (changed) begin
            run_d = CNT_W'(1);
        end else if (run_q >= RUN_MAX) begin
            run_d = RUN_MAX;
        end else begin
            run_d = run_q + CNT_W'(1);
        end
        // A change seen in REPORTED can be reported at once when STABLE_CYCLES=1.
        stable  = ((state_q == TRACK) || changed) && (run_d == RUN_MAX);
        state_d = state_q;
        if (stable) begin
            state_d = REPORTED;
        end else if (changed) begin
            state_d = TRACK;
        end
        pattern = pins;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            run_q    <= '0;
            state_q  <= TRACK;
        end else begin
            sample_q <= sample_d;
            run_q    <= run_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: rtl/seven_segment_encoder.sv
// Encodes stable 7-segment patterns back to 3-bit digit codes with one-cycle pulses.
// Define SEG_ERR_CNT_EN to add the saturating illegal-pattern counter port err_cnt.
module seven_segment_encoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seg_a,
    input  logic             seg_b,
    input  logic             seg_c,
    input  logic             seg_d,
    input  logic             seg_e,
    input  logic             seg_f,
    input  logic             seg_g,
    output logic [2:0]       code,
    output logic             code_valid,
    output logic             code_is_e,
    output logic             illegal
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic [6:0] pins;
    logic       stable;
    logic [6:0] pattern;

    logic [2:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       code_is_e_q, code_is_e_d;
    logic       illegal_q, illegal_d;

    assign pins = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    seg_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .pins    (pins),
        .stable  (stable),
        .pattern (pattern)
    );

    always_comb begin
        code_d       = code_q;
        code_valid_d = 1'b0;
        code_is_e_d  = 1'b0;
        illegal_d    = 1'b0;
        if (stable) begin
            case (pattern)
                SEG_0:     begin code_d = CODE_0; code_valid_d = 1'b1; end
                SEG_1:     begin code_d = CODE_1; code_valid_d = 1'b1; end
                SEG_2:     begin code_d = CODE_2; code_valid_d = 1'b1; end
                SEG_3:     begin code_d = CODE_3; code_valid_d = 1'b1; end
                SEG_E:     begin code_d = CODE_E; code_valid_d = 1'b1; code_is_e_d = 1'b1; end
                SEG_BLANK: ;
                default:   illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q       <= CODE_0;
            code_valid_q <= 1'b0;
            code_is_e_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            code_is_e_q  <= code_is_e_d;
            illegal_q    <= illegal_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign code_is_e  = code_is_e_q;
    assign illegal    = illegal_q;

`ifdef SEG_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (illegal_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seven_segment_encoder.sv
// Directed bench for seven_segment_encoder: one instance with STABLE_CYCLES=4,
// one with STABLE_CYCLES=1, both fed the same pins and reset.
module tb_seven_segment_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] pins = 7'b0000000;
    logic       sel = 1'b0;

    logic [2:0] code4, code1;
    logic       valid4, valid1, is_e4, is_e1, ill4, ill1;
`ifdef SEG_ERR_CNT_EN
    logic [7:0] err4, err1;
`endif

    always #5 clk = ~clk;

    seven_segment_encoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst),
        .seg_a(pins[6]), .seg_b(pins[5]), .seg_c(pins[4]), .seg_d(pins[3]),
        .seg_e(pins[2]), .seg_f(pins[1]), .seg_g(pins[0]),
        .code(code4), .code_valid(valid4), .code_is_e(is_e4), .illegal(ill4)
`ifdef SEG_ERR_CNT_EN
        , .err_cnt(err4)
`endif
    );

    seven_segment_encoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .seg_a(pins[6]), .seg_b(pins[5]), .seg_c(pins[4]), .seg_d(pins[3]),
        .seg_e(pins[2]), .seg_f(pins[1]), .seg_g(pins[0]),
        .code(code1), .code_valid(valid1), .code_is_e(is_e1), .illegal(ill1)
`ifdef SEG_ERR_CNT_EN
        , .err_cnt(err1)
`endif
    );

    logic [2:0] o_code;
    logic       o_valid, o_is_e, o_ill;
    assign o_code  = sel ? code1  : code4;
    assign o_valid = sel ? valid1 : valid4;
    assign o_is_e  = sel ? is_e1  : is_e4;
    assign o_ill   = sel ? ill1   : ill4;

    int n_total = 0;
    int n_bad   = 0;

    int nv, ni, ne, first_v, viol;
    logic [2:0] code_at_v;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold pattern p for n edges, tallying pulses on the selected instance.
    task automatic run_pat(input logic [6:0] p, input int n);
        nv = 0; ni = 0; ne = 0; first_v = 0; code_at_v = 3'b111;
        pins = p;
        for (int k = 1; k <= n; k++) begin
            step();
            if (o_is_e && !o_valid) viol++;
            if (o_valid && o_ill) viol++;
            if (o_valid) begin
                nv++;
                if (first_v == 0) first_v = k;
                code_at_v = o_code;
            end
            if (o_ill) ni++;
            if (o_is_e) ne++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        viol = 0;
        sel  = 1'b0;
        pins = 7'b0000000;
        do_reset();
        check_eq("rst_code", int'(o_code), 0);
        check_eq("rst_flags", int'({o_valid, o_is_e, o_ill}), 0);

        // 1: digit 0
        run_pat(7'b1111110, 6);
        check_eq("t1_nvalid", nv, 1);
        check_eq("t1_edge", first_v, 4);
        check_eq("t1_code", int'(code_at_v), 0);
        check_eq("t1_nis_e", ne, 0);

        // 2: short 2 then 1
        run_pat(7'b1101101, 3);
        check_eq("t2_short_pulses", nv + ni, 0);
        run_pat(7'b0110000, 6);
        check_eq("t2_nvalid", nv, 1);
        check_eq("t2_edge", first_v, 4);
        check_eq("t2_code", int'(code_at_v), 1);

        // 3: E
        run_pat(7'b1001111, 5);
        check_eq("t3_nvalid", nv, 1);
        check_eq("t3_code", int'(code_at_v), 4);
        check_eq("t3_nis_e", ne, 1);

        // 4: illegal
        run_pat(7'b1010101, 6);
        check_eq("t4_nillegal", ni, 1);
        check_eq("t4_nvalid", nv, 0);
        check_eq("t4_code_kept", int'(o_code), 4);
`ifdef SEG_ERR_CNT_EN
        check_eq("t4_err_cnt", int'(err4), 1);
`endif

        // 5: long hold, blank, then again
        run_pat(7'b1111001, 100);
        check_eq("t5_nvalid", nv, 1);
        check_eq("t5_code", int'(code_at_v), 3);
        run_pat(7'b0000000, 5);
        check_eq("t5_blank_pulses", nv + ni + ne, 0);
        check_eq("t5_code_kept", int'(o_code), 3);
        run_pat(7'b1111001, 6);
        check_eq("t5_again_nvalid", nv, 1);
        check_eq("t5_again_edge", first_v, 4);

        // 6: reset mid-run
        run_pat(7'b0110000, 3);
        check_eq("t6_pre_pulses", nv + ni, 0);
        do_reset();
        check_eq("t6_rst_code", int'(o_code), 0);
        check_eq("t6_rst_flags", int'({o_valid, o_is_e, o_ill}), 0);
`ifdef SEG_ERR_CNT_EN
        check_eq("t6_rst_err_cnt", int'(err4), 0);
`endif
        run_pat(7'b0110000, 6);
        check_eq("t6_nvalid", nv, 1);
        check_eq("t6_edge", first_v, 4);
        check_eq("t6_code", int'(code_at_v), 1);

        // STABLE_CYCLES=1
        sel  = 1'b1;
        pins = 7'b0000000;
        do_reset();
        run_pat(7'b0000000, 1);
        check_eq("s1_blank_first", nv + ni + ne, 0);
        run_pat(7'b1111110, 3);
        check_eq("s1_t1_nvalid", nv, 1);
        check_eq("s1_t1_edge", first_v, 1);
        check_eq("s1_t1_code", int'(code_at_v), 0);
        run_pat(7'b1101101, 1);
        check_eq("s1_t2a_nvalid", nv, 1);
        check_eq("s1_t2a_code", int'(code_at_v), 2);
        run_pat(7'b0110000, 4);
        check_eq("s1_t2_nvalid", nv, 1);
        check_eq("s1_t2_edge", first_v, 1);
        check_eq("s1_t2_code", int'(code_at_v), 1);
        run_pat(7'b1010101, 2);
        check_eq("s1_ill", ni, 1);

        check_eq("pulse_rules", viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
